mips_phase_sequencer: RTL and testbench

Single-clock multi-cycle phase controller for the MIPS processor core. It issues one-cycle and handshaked enables to instruction memory, register file, ALU, data memory and PC in place of divided phase clocks. All datapath elements run on the one system clock and are gated by this block's enables. It also handles memory wait-states, halt requests, bus-timeout faults and a retired-instruction counter.

---
 rtl/mips_phase_sequencer.sv | 117 +++++++++++
 tb/tb_mips_phase_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_phase_sequencer.sv
// Multi-cycle phase controller for the MIPS core: issues per-stage enables on the
// single system clock, handles memory wait-states, halts, bus timeouts and retire count.
module mips_phase_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             is_mem_op,
  input  logic             is_wb_op,
  output logic             imem_en,
  output logic             regfile_rd_en,
  output logic             alu_en,
  output logic             dmem_en,
  output logic             regfile_we,
  output logic             pc_en,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              complete;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wb_pend;
  logic              halt_lat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      wb_pend     <= 1'b0;
      halt_lat    <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (next_state != state && (next_state == S_FETCH || next_state == S_MEM))
        wait_cnt <= '0;
      else if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state == S_EXEC)
        wb_pend <= is_wb_op;
      // Latch clears on entry to HALTED and while parked; requests outside busy are ignored.
      if (next_state == S_HALTED || state == S_IDLE || state == S_HALTED)
        halt_lat <= 1'b0;
      else if (busy && halt_req)
        halt_lat <= 1'b1;
      if (complete)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    case (state)
      S_IDLE, S_HALTED: if (start) next_state = S_FETCH;
      S_FETCH: begin
        if (imem_ready)               next_state = S_DECODE;
        else if (wait_cnt == WAIT_LAST) next_state = S_FAULT;
      end
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (is_mem_op)     next_state = S_MEM;
        else if (is_wb_op) next_state = S_WB;
        else               complete   = 1'b1;
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (wb_pend) next_state = S_WB;
          else         complete   = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_FAULT;
        end
      end
      S_WB:    complete   = 1'b1;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
    if (complete)
      next_state = (halt_lat || halt_req) ? S_HALTED : S_FETCH;
  end

  always_comb begin
    imem_en       = (state == S_FETCH);
    regfile_rd_en = (state == S_DECODE);
    alu_en        = (state == S_EXEC);
    dmem_en       = (state == S_MEM);
    regfile_we    = (state == S_WB);
    busy          = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                    (state == S_MEM) || (state == S_WB);
    fault         = (state == S_FAULT);
    pc_en         = complete;
    phase         = state;
  end

endmodule

// File: tb/tb_mips_phase_sequencer.sv
// Directed and randomized checks of mips_phase_sequencer against a per-instruction
// phase-sequence model; a CNT_W=4 twin shares the stimulus to cover counter wrap.
module tb_mips_phase_sequencer;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3;
  localparam int P_MEM = 4, P_WB = 5, P_HALTED = 6, P_FAULT = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, halt_req = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic is_mem_op = 1'b0, is_wb_op = 1'b0;

  logic imem_en, regfile_rd_en, alu_en, dmem_en, regfile_we, pc_en, busy, fault;
  logic [2:0]  phase;
  logic [31:0] instr_count;

  logic imem_en_s, regfile_rd_en_s, alu_en_s, dmem_en_s, regfile_we_s, pc_en_s, busy_s, fault_s;
  logic [2:0] phase_s;
  logic [3:0] instr_count_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] cnt_model = '0;

  always #5 clock = ~clock;

  mips_phase_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .is_mem_op(is_mem_op), .is_wb_op(is_wb_op),
    .imem_en(imem_en), .regfile_rd_en(regfile_rd_en), .alu_en(alu_en), .dmem_en(dmem_en),
    .regfile_we(regfile_we), .pc_en(pc_en), .phase(phase), .busy(busy), .fault(fault),
    .instr_count(instr_count)
  );

  mips_phase_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .is_mem_op(is_mem_op), .is_wb_op(is_wb_op),
    .imem_en(imem_en_s), .regfile_rd_en(regfile_rd_en_s), .alu_en(alu_en_s), .dmem_en(dmem_en_s),
    .regfile_we(regfile_we_s), .pc_en(pc_en_s), .phase(phase_s), .busy(busy_s), .fault(fault_s),
    .instr_count(instr_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int ph, input bit pc);
    chk("phase",         32'(phase),         32'(ph));
    chk("imem_en",       32'(imem_en),       32'(ph == P_FETCH));
    chk("regfile_rd_en", 32'(regfile_rd_en), 32'(ph == P_DECODE));
    chk("alu_en",        32'(alu_en),        32'(ph == P_EXEC));
    chk("dmem_en",       32'(dmem_en),       32'(ph == P_MEM));
    chk("regfile_we",    32'(regfile_we),    32'(ph == P_WB));
    chk("pc_en",         32'(pc_en),         32'(pc));
    chk("busy",          32'(busy),          32'(ph >= P_FETCH && ph <= P_WB));
    chk("fault",         32'(fault),         32'(ph == P_FAULT));
    chk("instr_count",   instr_count,        cnt_model);
    chk("phase_s",       32'(phase_s),       32'(ph));
    chk("pc_en_s",       32'(pc_en_s),       32'(pc));
    chk("instr_count_s", 32'(instr_count_s), {28'b0, cnt_model[3:0]});
  endtask

  task automatic chk_cycle(input int ph, input bit pc);
    @(negedge clock);
    chk_all(ph, pc);
    @(posedge clock);
    #1;
  endtask

  task automatic noise();
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    is_mem_op  = 1'($urandom);
    is_wb_op   = 1'($urandom);
    start      = 1'b0;
    halt_req   = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    cnt_model = '0;
    #1;
    chk_all(P_IDLE, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input int ph);
    for (int i = 0; i < n; i++) begin
      noise();
      halt_req = 1'($urandom);
      chk_cycle(ph, 1'b0);
    end
  endtask

  task automatic start_run(input bit with_halt, input int ph);
    noise();
    start    = 1'b1;
    halt_req = with_halt;
    chk_cycle(ph, 1'b0);
    start    = 1'b0;
    halt_req = 1'b0;
  endtask

  // One instruction from FETCH entry: expected phase list built from wait counts and op type.
  task automatic run_instr(input int di, input int dd, input bit mem, input bit wb, input int halt_at);
    int q[$];
    int fi, mi;
    fi = 0;
    mi = 0;
    for (int i = 0; i <= di; i++) q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    q.push_back(P_EXEC);
    if (mem) for (int i = 0; i <= dd; i++) q.push_back(P_MEM);
    if (wb) q.push_back(P_WB);
    for (int k = 0; k < q.size(); k++) begin
      noise();
      if (q[k] == P_FETCH) begin
        imem_ready = (fi == di);
        fi++;
      end else if (q[k] == P_MEM) begin
        dmem_ready = (mi == dd);
        mi++;
      end else if (q[k] == P_EXEC) begin
        is_mem_op = mem;
        is_wb_op  = wb;
      end
      halt_req = (k == halt_at);
      chk_cycle(q[k], k == q.size() - 1);
    end
    halt_req = 1'b0;
    cnt_model++;
  endtask

  initial begin
    int di, dd, sz, ha;
    bit mm, wb;

    @(posedge clock);
    #1;
    reset_dut();
    idle_cycles(2, P_IDLE);

    // ALU with writeback, then a load with fetch and data wait-states
    start_run(1'b0, P_IDLE);
    run_instr(0, 0, 1'b0, 1'b1, -1);
    run_instr(2, 3, 1'b1, 1'b1, -1);
    // Ready on the last tolerated cycle is accepted
    run_instr(14, 14, 1'b1, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      di = $urandom_range(0, 4);
      dd = $urandom_range(0, 4);
      mm = 1'($urandom);
      wb = 1'($urandom);
      sz = di + 3 + (mm ? dd + 1 : 0) + (wb ? 1 : 0);
      ha = ($urandom_range(0, 5) == 0) ? $urandom_range(0, sz - 1) : -1;
      run_instr(di, dd, mm, wb, ha);
      if (ha >= 0) begin
        idle_cycles(2, P_HALTED);
        start_run(1'($urandom), P_HALTED);
      end
    end

    // Halt during DECODE of a store; resume with start and halt_req together
    run_instr(0, 0, 1'b1, 1'b0, 1);
    idle_cycles(1, P_HALTED);
    start_run(1'b1, P_HALTED);
    run_instr(0, 0, 1'b0, 1'b0, -1);

    // Data memory never ready: fault after MEM_TIMEOUT cycles, then absorbing
    noise(); imem_ready = 1'b1; chk_cycle(P_FETCH, 1'b0);
    noise(); chk_cycle(P_DECODE, 1'b0);
    noise(); is_mem_op = 1'b1; chk_cycle(P_EXEC, 1'b0);
    for (int i = 0; i < 15; i++) begin
      noise();
      dmem_ready = 1'b0;
      chk_cycle(P_MEM, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      noise();
      start = 1'b1;
      chk_cycle(P_FAULT, 1'b0);
    end
    start = 1'b0;

    reset_dut();
    idle_cycles(1, P_IDLE);

    // 17 zero-wait instructions wrap the 4-bit twin counter to 1
    start_run(1'b0, P_IDLE);
    for (int i = 0; i < 17; i++) run_instr(0, 0, 1'b0, 1'b0, -1);
    chk("wrap_count_s", 32'(instr_count_s), 32'd1);

    // Asynchronous reset in the middle of a MEM wait
    noise(); imem_ready = 1'b1; chk_cycle(P_FETCH, 1'b0);
    noise(); chk_cycle(P_DECODE, 1'b0);
    noise(); is_mem_op = 1'b1; chk_cycle(P_EXEC, 1'b0);
    for (int i = 0; i < 2; i++) begin
      noise();
      dmem_ready = 1'b0;
      chk_cycle(P_MEM, 1'b0);
    end
    #2;
    reset = 1'b0;
    cnt_model = '0;
    #1;
    chk_all(P_IDLE, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle_cycles(3, P_IDLE);
    start_run(1'b0, P_IDLE);
    run_instr(1, 1, 1'b1, 1'b1, -1);
    noise();
    chk_cycle(P_FETCH, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
